// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-cache port arbiter: FSM state encoding and requester IDs.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mem_arb_pkg;

  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_BUSY = 1'b1;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LSU   = 1'b1;

  typedef enum logic {
    ST_IDLE = ARB_IDLE,
    ST_BUSY = ARB_BUSY
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, LSU and data-cache handshakes around the port arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until their valid pulse; the cache answers with a one-cycle data_valid.
// Modports: master = arbiter side, slave = requesters plus cache (the environment).
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4
) ();

  // Fetch requester (read-only)
  logic                       r0_req;
  logic [DATA_WIDTH-1:0]      r0_addr;
  logic                       r0_valid;
  logic [DATA_WIDTH-1:0]      r0_rdata;

  // LSU requester
  logic                       r1_req;
  logic                       r1_we;
  logic [DATA_WIDTH-1:0]      r1_addr;
  logic [DATA_WIDTH-1:0]      r1_wdata;
  logic [BYTE_DATA_WIDTH-1:0] r1_byte_enable;
  logic                       r1_valid;
  logic [DATA_WIDTH-1:0]      r1_rdata;

  // Data-cache port
  logic                       data_req;
  logic                       data_we;
  logic [DATA_WIDTH-1:0]      data_addr;
  logic [DATA_WIDTH-1:0]      wdata;
  logic [BYTE_DATA_WIDTH-1:0] byte_enable;
  logic                       data_valid;
  logic [DATA_WIDTH-1:0]      rdata;

  modport master (
    input  r0_req, r0_addr,
    input  r1_req, r1_we, r1_addr, r1_wdata, r1_byte_enable,
    input  data_valid, rdata,
    output r0_valid, r0_rdata, r1_valid, r1_rdata,
    output data_req, data_we, data_addr, wdata, byte_enable
  );

  modport slave (
    output r0_req, r0_addr,
    output r1_req, r1_we, r1_addr, r1_wdata, r1_byte_enable,
    output data_valid, rdata,
    input  r0_valid, r0_rdata, r1_valid, r1_rdata,
    input  data_req, data_we, data_addr, wdata, byte_enable
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch (0) and LSU (1).
// Latency: zero (pure combinational).
// Backpressure: none; grant_valid is simply the OR of the requests.
// Ports: r0_req, r1_req, last_winner in; grant_valid, grant_id out.
// Build option MEM_ARB_RR_EN: ties go to the requester that did not win last; otherwise the LSU wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic r0_req,
  input  logic r1_req,
  input  logic last_winner,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = r0_req | r1_req;
    grant_id    = REQ_LSU;
    if (r0_req && !r1_req) begin
      grant_id = REQ_FETCH;
    end else if (r0_req && r1_req) begin
`ifdef MEM_ARB_RR_EN
      grant_id = ~last_winner;
`else
      grant_id = REQ_LSU;
`endif
    end
  end

`ifndef MEM_ARB_RR_EN
  // History is still tracked by the parent but only consulted in round-robin builds.
  logic unused_last_winner;
  assign unused_last_winner = last_winner;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single data-cache port between fetch (requester 0) and the LSU (requester 1).
// Latency: data_req one cycle after the winning req is sampled in IDLE; valid is combinational on data_valid.
// Backpressure: one transaction outstanding; losers hold req and are taken on the next IDLE cycle.
// Ports: clk, rst (async active-high), bus (mem_port_arbiter_if.master: requester and cache handshakes).
// Build option MEM_ARB_RR_EN selects round-robin tie-break inside mem_arb_pick.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
);

  arb_state_e                 state_q, state_d;
  logic                       grant_q, grant_d;
  logic                       last_winner_q, last_winner_d;
  logic                       data_req_q, data_req_d;
  logic                       data_we_q, data_we_d;
  logic [DATA_WIDTH-1:0]      data_addr_q, data_addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [BYTE_DATA_WIDTH-1:0] byte_enable_q, byte_enable_d;

  logic pick_valid;
  logic pick_id;
  logic done;

  mem_arb_pick u_pick (
    .r0_req      (bus.r0_req),
    .r1_req      (bus.r1_req),
    .last_winner (last_winner_q),
    .grant_valid (pick_valid),
    .grant_id    (pick_id)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_winner_d = last_winner_q;
    data_req_d    = data_req_q;
    data_we_d     = data_we_q;
    data_addr_d   = data_addr_q;
    wdata_d       = wdata_q;
    byte_enable_d = byte_enable_q;

    case (state_q)
      ST_IDLE: begin
        // data_valid is deliberately ignored here: nothing is outstanding.
        if (pick_valid) begin
          state_d    = ST_BUSY;
          grant_d    = pick_id;
          data_req_d = 1'b1;
          if (pick_id == REQ_LSU) begin
            data_we_d     = bus.r1_we;
            data_addr_d   = bus.r1_addr;
            wdata_d       = bus.r1_wdata;
            byte_enable_d = bus.r1_byte_enable;
          end else begin
            // Fetch is always a full-word read.
            data_we_d     = 1'b0;
            data_addr_d   = bus.r0_addr;
            wdata_d       = '0;
            byte_enable_d = '1;
          end
        end
      end
      ST_BUSY: begin
        // Output registers stay frozen until the cache completes.
        if (bus.data_valid) begin
          state_d       = ST_IDLE;
          data_req_d    = 1'b0;
          data_we_d     = 1'b0;
          last_winner_d = grant_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= REQ_FETCH;
      last_winner_q <= REQ_LSU;
      data_req_q    <= 1'b0;
      data_we_q     <= 1'b0;
      data_addr_q   <= '0;
      wdata_q       <= '0;
      byte_enable_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_winner_q <= last_winner_d;
      data_req_q    <= data_req_d;
      data_we_q     <= data_we_d;
      data_addr_q   <= data_addr_d;
      wdata_q       <= wdata_d;
      byte_enable_q <= byte_enable_d;
    end
  end

  // Completion is routed straight through to the granted requester in the same cycle.
  assign done = (state_q == ST_BUSY) && bus.data_valid;

  assign bus.r0_valid = done && (grant_q == REQ_FETCH);
  assign bus.r1_valid = done && (grant_q == REQ_LSU);
  assign bus.r0_rdata = (grant_q == REQ_FETCH) ? bus.rdata : '0;
  assign bus.r1_rdata = (grant_q == REQ_LSU)   ? bus.rdata : '0;

  assign bus.data_req    = data_req_q;
  assign bus.data_we     = data_we_q;
  assign bus.data_addr   = data_addr_q;
  assign bus.wdata       = wdata_q;
  assign bus.byte_enable = byte_enable_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table of request scenarios feeding an expected-grant queue,
// plus hand-written sequences for reset, spurious completion and reset during a transaction.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4)) ifc ();

  mem_port_arbiter #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {
    logic        r0_req;
    logic        r1_req;
    logic        r1_we;
    logic [31:0] r0_addr;
    logic [31:0] r1_addr;
    logic [31:0] r1_wdata;
    logic [3:0]  r1_be;
    logic [31:0] r0_rdata;
    logic [31:0] r1_rdata;
    int          lat;
    logic [31:0] chg_addr;
  } vec_t;

  typedef struct {
    logic        id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] chg_addr;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   errors = 0;
  int   checks = 0;
  logic model_last = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Queue the expected grant order for one scenario.
  task automatic push_vec(input vec_t v);
    exp_t e0, e1;
    logic first;
    e0 = '{1'b0, 1'b0, v.r0_addr, 32'd0, 4'hF, v.r0_rdata, v.lat, 32'd0};
    e1 = '{1'b1, v.r1_we, v.r1_addr, v.r1_wdata, v.r1_be, v.r1_rdata, v.lat, v.chg_addr};
    if (v.r0_req && v.r1_req) begin
`ifdef MEM_ARB_RR_EN
      first = ~model_last;
`else
      first = 1'b1;
`endif
      if (first) begin
        sb.push_back(e1);
        sb.push_back(e0);
      end else begin
        sb.push_back(e0);
        sb.push_back(e1);
      end
    end else if (v.r1_req) begin
      sb.push_back(e1);
    end else if (v.r0_req) begin
      sb.push_back(e0);
    end
  endtask

  // Act as the cache: wait for each expected request, check it, answer after e.lat cycles.
  task automatic serve();
    exp_t e;
    int   cyc;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      cyc = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        cyc++;
        if (ifc.data_req === 1'b1) break;
      end
      check("req_latency", 32'(cyc), 32'd1);
      if (ifc.data_req !== 1'b1) begin
        ifc.r0_req = 1'b0;
        ifc.r1_req = 1'b0;
        sb.delete();
        break;
      end
      check("data_we",     32'(ifc.data_we), 32'(e.we));
      check("data_addr",   ifc.data_addr, e.addr);
      check("wdata",       ifc.wdata, e.wdata);
      check("byte_enable", 32'(ifc.byte_enable), 32'(e.be));
      for (int i = 0; i < e.lat; i++) begin
        if (e.id && e.chg_addr != 32'd0) ifc.r1_addr = e.chg_addr;
        #1;
        check("busy_addr_hold", ifc.data_addr, e.addr);
        check("busy_no_valid", 32'({ifc.r0_valid, ifc.r1_valid}), 32'd0);
        tick();
      end
      ifc.data_valid = 1'b1;
      ifc.rdata      = e.rdata;
      #1;
      check("busy_addr_at_done", ifc.data_addr, e.addr);
      if (e.id) begin
        check("r1_valid",       32'(ifc.r1_valid), 32'd1);
        check("r0_valid_quiet", 32'(ifc.r0_valid), 32'd0);
        check("r1_rdata",       ifc.r1_rdata, e.rdata);
        check("r0_rdata_zero",  ifc.r0_rdata, 32'd0);
      end else begin
        check("r0_valid",       32'(ifc.r0_valid), 32'd1);
        check("r1_valid_quiet", 32'(ifc.r1_valid), 32'd0);
        check("r0_rdata",       ifc.r0_rdata, e.rdata);
        check("r1_rdata_zero",  ifc.r1_rdata, 32'd0);
      end
      tick();
      ifc.data_valid = 1'b0;
      ifc.rdata      = 32'd0;
      check("bubble_req_low", 32'(ifc.data_req), 32'd0);
      check("done_we_low",    32'(ifc.data_we), 32'd0);
      check("post_valid_low", 32'({ifc.r0_valid, ifc.r1_valid}), 32'd0);
      if (e.id) ifc.r1_req = 1'b0;
      else      ifc.r0_req = 1'b0;
      model_last = e.id;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    ifc.r0_req = 1'b0; ifc.r0_addr = 32'd0;
    ifc.r1_req = 1'b0; ifc.r1_we = 1'b0; ifc.r1_addr = 32'd0;
    ifc.r1_wdata = 32'd0; ifc.r1_byte_enable = 4'd0;
    ifc.data_valid = 1'b0; ifc.rdata = 32'd0;

    //                 r0  r1  we   r0_addr   r1_addr   r1_wdata      be      r0_rdata      r1_rdata    lat chg_addr
    vecs[0] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h100, 32'hDEADBEEF, 4'b0011, 32'h0,        32'hA5A5A5A5, 3, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h40,  32'h0,   32'h0,        4'h0,    32'h12345678, 32'h0,        0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h80,  32'h300, 32'h0,        4'hF,    32'h11112222, 32'h33334444, 1, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h100, 32'hCAFEF00D, 4'b1100, 32'h0,        32'h0,        2, 32'h200};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'hC0,  32'h400, 32'h0BADF00D, 4'b0110, 32'h55556666, 32'h77778888, 0, 32'h0};

    // Reset state, with a stray completion presented while in reset.
    #12;
    ifc.data_valid = 1'b1;
    #1;
    check("rst_data_req",    32'(ifc.data_req), 32'd0);
    check("rst_data_we",     32'(ifc.data_we), 32'd0);
    check("rst_data_addr",   ifc.data_addr, 32'd0);
    check("rst_wdata",       ifc.wdata, 32'd0);
    check("rst_byte_enable", 32'(ifc.byte_enable), 32'd0);
    check("rst_valids",      32'({ifc.r0_valid, ifc.r1_valid}), 32'd0);
    ifc.data_valid = 1'b0;
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      ifc.r0_addr        = vecs[v].r0_addr;
      ifc.r1_we          = vecs[v].r1_we;
      ifc.r1_addr        = vecs[v].r1_addr;
      ifc.r1_wdata       = vecs[v].r1_wdata;
      ifc.r1_byte_enable = vecs[v].r1_be;
      ifc.r0_req         = vecs[v].r0_req;
      ifc.r1_req         = vecs[v].r1_req;
      push_vec(vecs[v]);
      serve();
    end

    // Spurious completion while idle.
    ifc.data_valid = 1'b1;
    ifc.rdata      = 32'hFFFF0000;
    #1;
    check("idle_dv_r0_valid", 32'(ifc.r0_valid), 32'd0);
    check("idle_dv_r1_valid", 32'(ifc.r1_valid), 32'd0);
    tick();
    check("idle_dv_req", 32'(ifc.data_req), 32'd0);
    ifc.data_valid = 1'b0;
    ifc.rdata      = 32'd0;
    tick();
    check("idle_dv_req_later", 32'(ifc.data_req), 32'd0);

    // Reset in the middle of an LSU transaction.
    ifc.r1_we = 1'b1; ifc.r1_addr = 32'h500; ifc.r1_wdata = 32'h01020304; ifc.r1_byte_enable = 4'hF;
    ifc.r1_req = 1'b1;
    tick();
    check("mid_rst_req_up", 32'(ifc.data_req), 32'd1);
    #3;
    rst = 1'b1;
    ifc.data_valid = 1'b1;
    ifc.rdata = 32'h99999999;
    #1;
    check("mid_rst_req_drop", 32'(ifc.data_req), 32'd0);
    check("mid_rst_we_drop",  32'(ifc.data_we), 32'd0);
    check("mid_rst_no_valid", 32'({ifc.r0_valid, ifc.r1_valid}), 32'd0);
    #1;
    rst = 1'b0;
    ifc.r1_req = 1'b0;
    ifc.data_valid = 1'b0;
    ifc.rdata = 32'd0;
    tick();
    check("post_rst_idle", 32'(ifc.data_req), 32'd0);
    check("post_rst_no_valid", 32'({ifc.r0_valid, ifc.r1_valid}), 32'd0);

    // A fetch after the reset is served normally.
    ifc.r0_addr = 32'h44;
    ifc.r0_req  = 1'b1;
    sb.push_back('{1'b0, 1'b0, 32'h44, 32'd0, 4'hF, 32'hABCD0123, 1, 32'd0});
    serve();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-cache port between two requesters: instruction fetch (requester 0) and the load/store unit (requester 1).
- Latches the winning request and drives it to the cache, holding it stable until the cache signals completion.
- Routes the completion pulse and read data back to the winning requester only.
- Sits between fetch/LSU and the data cache.

Parameters:
- DATA_WIDTH, 32, width of address and data buses.
- BYTE_DATA_WIDTH, 4, number of byte-enable bits (DATA_WIDTH/8).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- r0_req  in  1  fetch request, held high until r0_valid
- r0_addr  in  DATA_WIDTH  fetch address
- r0_valid  out  1  fetch completion pulse
- r0_rdata  out  DATA_WIDTH  fetch read data
- r1_req  in  1  LSU request, held high until r1_valid
- r1_we  in  1  LSU write enable
- r1_addr  in  DATA_WIDTH  LSU address
- r1_wdata  in  DATA_WIDTH  LSU write data
- r1_byte_enable  in  BYTE_DATA_WIDTH  LSU byte enables
- r1_valid  out  1  LSU completion pulse
- r1_rdata  out  DATA_WIDTH  LSU read data
- data_req  out  1  cache request
- data_we  out  1  cache write enable
- data_addr  out  DATA_WIDTH  cache address
- wdata  out  DATA_WIDTH  cache write data
- byte_enable  out  BYTE_DATA_WIDTH  cache byte enables
- data_valid  in  1  cache completion, one-cycle pulse
- rdata  in  DATA_WIDTH  cache read data, valid with data_valid

Behaviour:
- Reset (async, rst=1): state IDLE, grant=0, last_winner=1. data_req, data_we, data_addr, wdata and byte_enable are all 0. r0_valid=r1_valid=0.
- States:
  - IDLE: no transaction outstanding.
  - BUSY: transaction outstanding on the cache port.
- IDLE with any reqN=1 at a clock edge:
  - Select a winner and register its addr/we/wdata/byte_enable into the output registers.
  - Set data_req=1 and move to BUSY.
  - Requester 0 is always driven as we=0, byte_enable all ones, wdata=0.
- Latency: data_req rises the cycle after the winning req is first sampled. Minimum request-to-valid is 2 cycles, reached when the cache answers in the first BUSY cycle.
- BUSY: output registers are frozen and requester inputs are ignored.
- BUSY with data_valid=1:
  - The same cycle, combinationally: rN_valid=1 for the granted requester only, and rN_rdata=rdata.
  - At the clock edge: data_req=0, data_we=0, state goes to IDLE, last_winner=grant.
- Non-granted rN_valid is always 0. rN_rdata of the non-granted port is 0.
- data_valid in IDLE is ignored: no valid to either requester, no state change.
- A requester must drop req in the cycle after its valid. A req sampled high in IDLE is always treated as a new request.
- Simultaneous r0_req and r1_req in IDLE: fixed priority, LSU (r1) wins. Optional round-robin is described below.
- The loser keeps req high and is granted on the next IDLE cycle. This gives one IDLE bubble between transactions.
- rst asserted mid-transaction: return to IDLE immediately and drop data_req. The outstanding completion is never reported.

Optional Feature:
- MEM_ARB_RR_EN defined: on simultaneous requests the requester that is not last_winner wins, i.e. round-robin.
- MEM_ARB_RR_EN undefined: LSU always wins ties. last_winner is still maintained but unused.

Decomposition:
- Package mem_arb_pkg holds:
  - State encoding localparams: ARB_IDLE=0, ARB_BUSY=1.
  - Requester IDs: REQ_FETCH=0, REQ_LSU=1.
- One sub-module, mem_arb_pick:
  - Purely combinational winner select.
  - Inputs: r0_req, r1_req, last_winner.
  - Outputs: grant_valid, grant_id.
  - Holds the MEM_ARB_RR_EN switch.

Test Plan:
- Single LSU write: r1_req=1, we=1, addr=0x100, wdata=0xDEADBEEF, be=4'b0011. Expect data_req high next cycle with exactly these values. Cache valid after 3 cycles gives r1_valid one cycle; r0_valid stays 0.
- Single fetch read: r0_req=1, addr=0x40. Expect data_we=0 and be=4'hF. rdata=0x12345678 with data_valid gives r0_rdata=0x12345678 and r0_valid=1 that cycle.
- Tie: r0_req and r1_req both rise the same cycle.
  - Fixed priority: LSU served first, then fetch after one IDLE bubble.
  - MEM_ARB_RR_EN with last_winner=LSU: fetch served first.
- Input change while BUSY: change r1_addr from 0x100 to 0x200 mid-transaction. data_addr must stay 0x100 until data_valid.
- Spurious data_valid in IDLE: r0_valid=r1_valid=0, data_req stays 0.
- Reset mid-BUSY: assert rst between clock edges. data_req goes 0 immediately (async), no valid is produced, and a later r0_req is served normally.
